// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types, defaults and address check for the data-memory arbiter
package dmem_arb_pkg;

    localparam int N_DEFAULT = 32;
    localparam int M_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Misaligned word access, or any address bit above the memory depth set.
    function automatic logic addr_bad(input logic [N_DEFAULT-1:0] addr, input int m);
        logic hi;
        hi = 1'b0;
        for (int i = 0; i < N_DEFAULT; i++) begin
            if (i >= m + 2 && addr[i]) hi = 1'b1;
        end
        return (addr[1:0] != 2'b00) || hi;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rtl/dmem_arbiter_rr_pick2.sv - two-way round-robin winner selection
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        // On a tie the port that did not win last time goes next.
        grant_id    = (req0 && req1) ? ~last_grant : req1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin sequencer in front of the data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] addr1,
    input  logic [N-1:0] wdata0,
    input  logic [N-1:0] wdata1,
    output logic         ack0,
    output logic         ack1,
    output logic [N-1:0] rdata0,
    output logic [N-1:0] rdata1,
    output logic         err0,
    output logic         err1,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    state_t       state;
    logic         last_grant;
    logic         lat_id;
    logic         lat_we;
    logic [N-1:0] lat_addr;
    logic [N-1:0] lat_wdata;

    logic         grant_valid;
    logic         grant_id;
    logic         bad;
    logic         in_access;
    logic [N-1:0] acc_rdata;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        bad       = addr_bad(N_DEFAULT'(lat_addr), M);
        // Gating with reset keeps a mid-transaction reset from writing or acking.
        in_access = (state == ACCESS) && !reset;
        mem_we    = in_access && lat_we && !bad;
        mem_addr  = in_access ? lat_addr  : '0;
        mem_wdata = in_access ? lat_wdata : '0;
        acc_rdata = (bad || lat_we) ? '0 : mem_rdata;
        ack0      = (state == RESP) && !reset && !lat_id;
        ack1      = (state == RESP) && !reset &&  lat_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        lat_id     <= grant_id;
                        lat_we     <= grant_id ? we1    : we0;
                        lat_addr   <= grant_id ? addr1  : addr0;
                        lat_wdata  <= grant_id ? wdata1 : wdata0;
                        last_grant <= grant_id;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_id) begin
                        rdata1 <= acc_rdata;
                        err1   <= bad;
                    end else begin
                        rdata0 <= acc_rdata;
                        err0   <= bad;
                    end
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the word-addressed data memory (combinational read, write on posedge clk).
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
- Each request is latched, applied to the memory for exactly one cycle, and answered with a one-cycle ack carrying registered read data or an error flag.

Parameters:
- N, 32, data and address width (bits).
- M, 5, log2 of memory depth in words (32 words).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from port 0 / 1; held high until the matching ack.
- we0 / we1  in  1  1 = store, 0 = load; stable while req high.
- addr0 / addr1  in  N  byte address; stable while req high.
- wdata0 / wdata1  in  N  store data; stable while req high.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  N  load data, valid only with ack.
- err0 / err1  out  1  access rejected, valid only with ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  N  memory byte address.
- mem_wdata  out  N  memory write data.
- mem_rdata  in  N  memory combinational read data.

Behaviour:
- Clock is clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - state = IDLE.
  - ack0/1 = 0, err0/1 = 0, rdata0/1 = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - last_grant = 1, so port 0 wins the first tie.
- States: IDLE -> ACCESS -> RESP -> IDLE. Fixed 3-cycle transaction; throughput is 1 access per 3 cycles.
- IDLE:
  - If req0 or req1 is high, pick the winner and latch its we, addr and wdata. Go to ACCESS.
  - Winner rule: only one requesting -> that one. Both requesting -> the port that is not last_grant.
  - Update last_grant to the winner. No request -> stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_we = latched_we AND NOT bad, where bad = (addr[1:0] != 0) OR (addr[N-1:M+2] != 0).
  - Capture mem_rdata into the winner's rdata register; capture 0 instead if bad or if the access is a store.
  - Capture err = bad. Go to RESP.
- RESP:
  - Pulse ack of the winner only; its rdata and err are valid this cycle.
  - Go to IDLE. The other port's ack stays 0.
- Outside ACCESS: mem_we = 0. mem_addr and mem_wdata hold 0 in IDLE.
- rdata and err hold their value until the next transaction by the same port; check them only with ack.
- Requester protocol:
  - The requester drops req, or presents a new request, in the cycle after its ack.
  - A request still high in the IDLE cycle following RESP is treated as a new request.
  - Changing we/addr/wdata while req is high and before ack is a protocol violation; the latched values win.
- Fairness: under continuous req0 = req1 = 1, grants strictly alternate 0,1,0,1.
- Store-then-load, same address, same or other port: the load returns the new data (the write commits at the end of ACCESS).
- Reset mid-transaction:
  - Reset in ACCESS: mem_we forced 0 that cycle, no write, no ack.
  - Reset in RESP: ack suppressed.
  - In both cases, next state is IDLE.
- A request arriving while the arbiter is busy waits; its req must stay high.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - Constants N_DEFAULT = 32 and M_DEFAULT = 5.
  - Function addr_bad(addr) returning the alignment/range check.
- Optional sub-module rr_pick2: inputs req0, req1, last_grant; outputs grant_valid, grant_id. Purely combinational; used only in IDLE.
- Main FSM, latch registers and response registers stay in dmem_arbiter.

Test Plan:
- Single store/load on port 0 (bench model memory depth 32):
  - Store 0xDEADBEEF to 0x0000000C, then load 0x0000000C.
  - Required: mem_we high exactly one cycle (ACCESS of the store), with mem_addr = 0x0C.
  - Required: the load's ack0 comes 2 cycles after acceptance, with rdata0 = 0xDEADBEEF and err0 = 0.
- Simultaneous requests from reset:
  - req0 = req1 = 1 held for 4 transactions.
  - Required: ack sequence is port 0, 1, 0, 1, with acks exactly 3 cycles apart.
- Misaligned store:
  - Port 1 stores 0x12345678 to 0x00000006.
  - Required: mem_we never asserts; ack1 with err1 = 1 and rdata1 = 0; a later load of 0x04 returns its previous content.
- Out-of-range load:
  - Port 0 loads 0x00000080 (word 32 is beyond depth 32).
  - Required: err0 = 1, rdata0 = 0.
- Cross-port coherence:
  - Port 1 stores 0x000000AA to 0x10 while port 0 has a load of 0x10 pending.
  - Required: port 1 is granted first (last_grant = 0 after a prior port-0 grant); port 0's load returns 0x000000AA.
- Reset in ACCESS:
  - Assert reset during the ACCESS cycle of a store of 0x55 to 0x08.
  - Required: no write (word 0x08 unchanged), no ack, all outputs 0, state IDLE on the next cycle.
